// File: rtl/divisor_seq.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Define DIVISOR_SIGNED_EN for two's-complement operands and results.
module divisor_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [WIDTH-1:0] Num,
   input  logic [WIDTH-1:0] Den,
   output logic             busy,
   output logic             done,
   output logic             er,
   output logic [WIDTH-1:0] Coc,
   output logic [WIDTH-1:0] Res
);
   localparam int unsigned     CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] quo, quo_nxt;
   logic [WIDTH-1:0] dvs, dvs_nxt;
   logic [WIDTH-1:0] coc_nxt, res_nxt;
   logic             busy_nxt, done_nxt, er_nxt;
   logic [WIDTH:0]   shifted, diff;
   logic             qbit;
   logic [WIDTH-1:0] rem_step, q_fin;
`ifdef DIVISOR_SIGNED_EN
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   logic neg_q, neg_q_nxt, neg_r, neg_r_nxt, ovf, ovf_nxt;
`endif

   // One restoring step; the extra bit keeps divisors near 2^WIDTH-1 exact
   assign shifted  = {rem, quo[WIDTH-1]};
   assign diff     = shifted - {1'b0, dvs};
   assign qbit     = (shifted >= {1'b0, dvs});
   assign rem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign q_fin    = {quo[WIDTH-2:0], qbit};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         er    <= 1'b0;
         Coc   <= '0;
         Res   <= '0;
`ifdef DIVISOR_SIGNED_EN
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rem   <= rem_nxt;
         quo   <= quo_nxt;
         dvs   <= dvs_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         er    <= er_nxt;
         Coc   <= coc_nxt;
         Res   <= res_nxt;
`ifdef DIVISOR_SIGNED_EN
         neg_q <= neg_q_nxt;
         neg_r <= neg_r_nxt;
         ovf   <= ovf_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rem_nxt   = rem;
      quo_nxt   = quo;
      dvs_nxt   = dvs;
      coc_nxt   = Coc;
      res_nxt   = Res;
      er_nxt    = er;
`ifdef DIVISOR_SIGNED_EN
      neg_q_nxt = neg_q;
      neg_r_nxt = neg_r;
      ovf_nxt   = ovf;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               if (Den == '0) begin
                  // Divide by zero resolves immediately, no iterations
                  state_nxt = DONE;
                  er_nxt    = 1'b1;
                  coc_nxt   = '1;
                  res_nxt   = Num;
               end else begin
                  state_nxt = CALC;
                  cnt_nxt   = '0;
                  rem_nxt   = '0;
`ifdef DIVISOR_SIGNED_EN
                  quo_nxt   = Num[WIDTH-1] ? (~Num + WIDTH'(1)) : Num;
                  dvs_nxt   = Den[WIDTH-1] ? (~Den + WIDTH'(1)) : Den;
                  neg_q_nxt = Num[WIDTH-1] ^ Den[WIDTH-1];
                  neg_r_nxt = Num[WIDTH-1];
                  ovf_nxt   = (Num == SMIN) && (Den == '1);
`else
                  quo_nxt   = Num;
                  dvs_nxt   = Den;
`endif
               end
            end
         end
         CALC: begin
            quo_nxt = q_fin;
            rem_nxt = rem_step;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == LAST) begin
               state_nxt = DONE;
`ifdef DIVISOR_SIGNED_EN
               // Truncating sign fix-up folded into the result load
               coc_nxt = neg_q ? (~q_fin + WIDTH'(1)) : q_fin;
               res_nxt = neg_r ? (~rem_step + WIDTH'(1)) : rem_step;
               er_nxt  = ovf;
`else
               coc_nxt = q_fin;
               res_nxt = rem_step;
               er_nxt  = 1'b0;
`endif
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == CALC);
      done_nxt = (state_nxt == DONE);
   end
endmodule
